// File: rtl/board_vga_renderer.sv
// -----------------------------------------------------------------------------
// board_vga_renderer
//   Pixel stage between the 16x16 game board and the VGA pins. It draws the
//   board as a centred 480x480 square of 30x30-pixel cells and registers RGB
//   together with hSync/vSync so that colour and sync stay aligned (2 clk).
//   The board is copied once per frame on the first blanked line after the
//   board (vCount 515), which keeps a frame tear-free. frame_pulse_o marks that
//   copy so the game machine can step a generation between frames.
//
//   Optional feature macro: BOARD_GRID_LINES_EN
//     defined   : the first pixel column/row of every cell is drawn in GRID_RGB
//     undefined : cells are filled completely (GRID_RGB does not exist)
//
// Ports
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   board_i        in   live map, bit row*16+col, row 0 top, col 0 left
//   hCount,vCount  in   display controller counters
//   bright         in   visible-area flag
//   hSync_i,vSync_i in  syncs from the display controller
//   rgb_o          out  registered pixel colour {R,G,B}
//   hSync_o,vSync_o out syncs delayed by 2 clk
//   frame_pulse_o  out  1-clk pulse when the board snapshot is taken
// -----------------------------------------------------------------------------
module board_vga_renderer #(
  parameter int unsigned H_BOARD_X0     = 224,
  parameter int unsigned V_ACTIVE_START = 35,
  parameter int unsigned CELL_PX        = 30,
  parameter int unsigned N              = 16,
  parameter logic [11:0] ALIVE_RGB      = 12'h0F0,
  parameter logic [11:0] DEAD_RGB       = 12'h111,
  parameter logic [11:0] BG_RGB         = 12'h000
`ifdef BOARD_GRID_LINES_EN
  , parameter logic [11:0] GRID_RGB     = 12'h444
`endif
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N*N-1:0] board_i,
  input  logic [9:0]     hCount,
  input  logic [9:0]     vCount,
  input  logic           bright,
  input  logic           hSync_i,
  input  logic           vSync_i,
  output logic [11:0]    rgb_o,
  output logic           hSync_o,
  output logic           vSync_o,
  output logic           frame_pulse_o
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned PW = $clog2(CELL_PX);

  localparam logic [9:0]    H_X0     = 10'(H_BOARD_X0);
  localparam logic [9:0]    V_Y0     = 10'(V_ACTIVE_START);
  localparam logic [9:0]    V_SNAP   = 10'(V_ACTIVE_START + N * CELL_PX);
  localparam logic [PW-1:0] PX_LAST  = PW'(CELL_PX - 1);
  localparam logic [CW-1:0] CELL_LAST = CW'(N - 1);

  // Pixel tick: the controller advances hCount at a divided rate, so a change
  // of hCount marks the start of a new pixel.
  logic [9:0] hc_q;
  logic       tick;
  logic       snap_now;

  logic [PW-1:0] xpix_q, xpix_d, ypix_q, ypix_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic          in_x_q, in_x_d, in_y_q, in_y_d;

  logic [N*N-1:0] snapshot_q;
  logic           frame_pulse_q;

  // Stage 1
  logic [2*CW-1:0] idx_s1_q;
  logic            in_board_s1_q;
  logic            bright_s1_q;
  logic            hs_s1_q, vs_s1_q;
`ifdef BOARD_GRID_LINES_EN
  logic            grid_s1_q;
`endif

  // Stage 2
  logic [11:0] rgb_q;
  logic        hs_q, vs_q;

  assign tick     = (hCount != hc_q);
  assign snap_now = tick && (hCount == '0) && (vCount == V_SNAP);

  // Next-state cell position. Stage 1 samples the _d values so the position
  // belongs to the same pixel as the hCount being registered.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave a latch.
    xpix_d = xpix_q;
    col_d  = col_q;
    in_x_d = in_x_q;
    ypix_d = ypix_q;
    row_d  = row_q;
    in_y_d = in_y_q;

    if (tick) begin
      if (hCount == H_X0) begin
        xpix_d = '0;
        col_d  = '0;
        in_x_d = 1'b1;
      end else if (in_x_q) begin
        if (xpix_q == PX_LAST) begin
          xpix_d = '0;
          if (col_q == CELL_LAST) in_x_d = 1'b0;
          else                    col_d  = col_q + 1'b1;
        end else begin
          xpix_d = xpix_q + 1'b1;
        end
      end

      if (hCount == '0) begin
        if (vCount == V_Y0) begin
          ypix_d = '0;
          row_d  = '0;
          in_y_d = 1'b1;
        end else if (in_y_q) begin
          if (ypix_q == PX_LAST) begin
            ypix_d = '0;
            if (row_q == CELL_LAST) in_y_d = 1'b0;
            else                    row_d  = row_q + 1'b1;
          end else begin
            ypix_d = ypix_q + 1'b1;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its sources.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= '0;
      xpix_q        <= '0;
      col_q         <= '0;
      in_x_q        <= 1'b0;
      ypix_q        <= '0;
      row_q         <= '0;
      in_y_q        <= 1'b0;
      // NOTE: the 256-bit snapshot is plain flops, not a RAM, so it can be
      // reset; a cleared board shows dead cells rather than power-up noise.
      snapshot_q    <= '0;
      frame_pulse_q <= 1'b0;
      idx_s1_q      <= '0;
      in_board_s1_q <= 1'b0;
      bright_s1_q   <= 1'b0;
      hs_s1_q       <= 1'b1;
      vs_s1_q       <= 1'b1;
`ifdef BOARD_GRID_LINES_EN
      grid_s1_q     <= 1'b0;
`endif
      rgb_q         <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
    end else begin
      hc_q   <= hCount;
      xpix_q <= xpix_d;
      col_q  <= col_d;
      in_x_q <= in_x_d;
      ypix_q <= ypix_d;
      row_q  <= row_d;
      in_y_q <= in_y_d;

      // Line 515 is blanked, so replacing the board here never shows a tear.
      if (snap_now) snapshot_q <= board_i;
      frame_pulse_q <= snap_now;

      // Stage 1: cell index is a concat of row and column (N is a power of 2).
      idx_s1_q      <= {row_d, col_d};
      in_board_s1_q <= in_x_d & in_y_d;
      bright_s1_q   <= bright;
      hs_s1_q       <= hSync_i;
      vs_s1_q       <= vSync_i;
`ifdef BOARD_GRID_LINES_EN
      grid_s1_q     <= (xpix_d == '0) || (ypix_d == '0);
`endif

      // Stage 2: colour select.
      if (!bright_s1_q)                rgb_q <= '0;
      else if (!in_board_s1_q)         rgb_q <= BG_RGB;
`ifdef BOARD_GRID_LINES_EN
      else if (grid_s1_q)              rgb_q <= GRID_RGB;
`endif
      else if (snapshot_q[idx_s1_q])   rgb_q <= ALIVE_RGB;
      else                             rgb_q <= DEAD_RGB;
      hs_q <= hs_s1_q;
      vs_q <= vs_s1_q;
    end
  end

  assign rgb_o         = rgb_q;
  assign hSync_o       = hs_q;
  assign vSync_o       = vs_q;
  assign frame_pulse_o = frame_pulse_q;

endmodule

// File: tb/tb_board_vga_renderer.sv
// -----------------------------------------------------------------------------
// tb_board_vga_renderer
//   Directed bench for board_vga_renderer (default build). A compressed display
//   controller drives one pixel per clk: every line visits hCount 0 and 1 so
//   row tracking sees each line, and selected lines also sweep hCount 200..720
//   across the board. Expected colours come from a probe table of
//   {frame, vCount, hCount, rgb}; each probe is compared 2 clk after the pixel
//   was driven.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_board_vga_renderer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] board_i;
  logic [9:0]   hCount, vCount;
  logic         bright, hSync_i, vSync_i;
  logic [11:0]  rgb_o;
  logic         hSync_o, vSync_o, frame_pulse_o;

  always #5 clk = ~clk;

  board_vga_renderer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .board_i      (board_i),
    .hCount       (hCount),
    .vCount       (vCount),
    .bright       (bright),
    .hSync_i      (hSync_i),
    .vSync_i      (vSync_i),
    .rgb_o        (rgb_o),
    .hSync_o      (hSync_o),
    .vSync_o      (vSync_o),
    .frame_pulse_o(frame_pulse_o)
  );

  typedef struct {
    int          frame;
    int          v;
    int          h;
    logic [11:0] exp;
  } probe_t;

  probe_t probes[$];

  int n_cmp = 0;
  int n_bad = 0;

  int           frame_id;
  int           hist_v[2];
  int           hist_h[2];
  logic [255:0] brd;
  bit           toggle_en;
  bit           hs_low;
  int           cyc;
  int           pulse_cnt;

  logic [255:0] b_bit0;
  logic [255:0] b_bit255;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_full(input int v);
    return v inside {35, 64, 65, 300, 484, 485, 514};
  endfunction

  task automatic add_probe(input int f, input int v, input int h, input logic [11:0] e);
    probe_t p;
    p.frame = f; p.v = v; p.h = h; p.exp = e;
    probes.push_back(p);
  endtask

  task automatic clear_hist();
    hist_v[0] = -1; hist_v[1] = -1; hist_h[0] = -1; hist_h[1] = -1;
  endtask

  // One pixel: compare outputs from the previous edges, then drive the next pixel.
  task automatic step(input int v, input int h, input bit tog);
    @(posedge clk); #1;
    cyc++;
    foreach (probes[i])
      if (probes[i].frame == frame_id && probes[i].v == hist_v[1] && probes[i].h == hist_h[1])
        check($sformatf("rgb f%0d v%0d h%0d", frame_id, hist_v[1], hist_h[1]),
              32'(rgb_o), 32'(probes[i].exp));
    if (frame_pulse_o === 1'b1) begin
      pulse_cnt++;
      check("frame_pulse_position(v*1000+h)", 32'(hist_v[0] * 1000 + hist_h[0]), 32'd515000);
    end
    if (tog && toggle_en && (cyc % 50 == 0)) brd = ~brd;
    hCount  = 10'(h);
    vCount  = 10'(v);
    bright  = (h >= 144) && (h < 784) && (v >= 35) && (v < 515);
    hSync_i = (h >= 96) && !hs_low;
    vSync_i = (v >= 2);
    board_i = brd;
    hist_v[1] = hist_v[0]; hist_h[1] = hist_h[0];
    hist_v[0] = v;         hist_h[0] = h;
  endtask

  // Lines v0..524; board_i is forced to snap only on the snapshot clk.
  task automatic run_frame(input int fid, input int v0, input logic [255:0] snap);
    frame_id  = fid;
    pulse_cnt = 0;
    for (int v = v0; v < 525; v++) begin
      if (v == 515) begin
        brd = snap;  step(v, 0, 1'b0);
        brd = ~snap; step(v, 1, 1'b0);
      end else begin
        step(v, 0, 1'b1);
        step(v, 1, 1'b1);
        if (is_full(v))
          for (int h = 200; h <= 720; h++) step(v, h, 1'b1);
      end
    end
    check($sformatf("frame_pulse_count f%0d", fid), 32'(pulse_cnt), 32'd1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b_bit0   = '0; b_bit0[0]     = 1'b1;
    b_bit255 = '0; b_bit255[255] = 1'b1;

    // Frame 1: reset released at line 100, nothing drawn this frame.
    add_probe(1, 300, 230, 12'h000);
    add_probe(1, 300, 100, 12'h000);
    add_probe(1, 485, 680, 12'h000);
    add_probe(1, 514, 703, 12'h000);
    // Frame 2: single live cell at row 0, col 0.
    add_probe(2, 35, 224, 12'h0F0);
    add_probe(2, 35, 253, 12'h0F0);
    add_probe(2, 35, 254, 12'h111);
    add_probe(2, 35, 223, 12'h000);
    add_probe(2, 35, 200, 12'h000);
    add_probe(2, 35, 703, 12'h111);
    add_probe(2, 35, 704, 12'h000);
    add_probe(2, 64, 224, 12'h0F0);
    add_probe(2, 64, 253, 12'h0F0);
    add_probe(2, 65, 224, 12'h111);
    add_probe(2, 300, 400, 12'h111);
    add_probe(2, 300, 720, 12'h000);
    add_probe(2, 514, 703, 12'h111);
    // Frame 3: single live cell at row 15, col 15.
    add_probe(3, 485, 674, 12'h0F0);
    add_probe(3, 485, 703, 12'h0F0);
    add_probe(3, 485, 673, 12'h111);
    add_probe(3, 485, 704, 12'h000);
    add_probe(3, 514, 674, 12'h0F0);
    add_probe(3, 514, 703, 12'h0F0);
    add_probe(3, 484, 674, 12'h111);
    add_probe(3, 35, 224, 12'h111);
    // After the second reset: row tracking is off until line 35 again.
    add_probe(5, 36, 230, 12'h000);
    add_probe(5, 36, 260, 12'h000);

    clear_hist();
    frame_id  = 0;
    cyc       = 0;
    hs_low    = 1'b0;
    toggle_en = 1'b1;
    brd       = '1;
    reset_n   = 1'b0;
    hCount    = 10'd400;
    vCount    = 10'd100;
    bright    = 1'b1;
    hSync_i   = 1'b0;
    vSync_i   = 1'b0;
    board_i   = brd;

    repeat (3) @(posedge clk);
    #1;
    check("reset rgb_o", 32'(rgb_o), 32'h0);
    check("reset hSync_o", 32'(hSync_o), 32'd1);
    check("reset vSync_o", 32'(vSync_o), 32'd1);
    check("reset frame_pulse_o", 32'(frame_pulse_o), 32'd0);
    reset_n = 1'b1;

    // Board toggles every 50 clk throughout; only the line-515 value may show.
    run_frame(1, 100, b_bit0);
    run_frame(2, 0, b_bit255);
    run_frame(3, 0, b_bit255);

    // Sync latency: a one-pixel low on hSync_i, then on vSync_i.
    frame_id  = 4;
    toggle_en = 1'b0;
    step(520, 300, 1'b0);
    step(520, 301, 1'b0);
    hs_low = 1'b1;
    step(520, 302, 1'b0);
    hs_low = 1'b0;
    step(520, 303, 1'b0);
    check("hSync_o after 1 clk", 32'(hSync_o), 32'd1);
    step(520, 304, 1'b0);
    check("hSync_o after 2 clk", 32'(hSync_o), 32'd0);
    step(520, 305, 1'b0);
    check("hSync_o after 3 clk", 32'(hSync_o), 32'd1);
    step(1, 310, 1'b0);
    step(520, 311, 1'b0);
    check("vSync_o after 1 clk", 32'(vSync_o), 32'd1);
    step(520, 312, 1'b0);
    check("vSync_o after 2 clk", 32'(vSync_o), 32'd0);
    step(520, 313, 1'b0);
    check("vSync_o after 3 clk", 32'(vSync_o), 32'd1);

    // Mid-line reset while a dead cell is on screen.
    frame_id = 6;
    for (int v = 521; v < 525; v++) begin step(v, 0, 1'b0); step(v, 1, 1'b0); end
    for (int v = 0; v < 35; v++)    begin step(v, 0, 1'b0); step(v, 1, 1'b0); end
    step(35, 0, 1'b0);
    step(35, 1, 1'b0);
    for (int h = 200; h <= 240; h++) step(35, h, 1'b0);
    check("pre-reset rgb_o (row 0 col 0 dead)", 32'(rgb_o), 32'h111);
    hSync_i = 1'b0;
    vSync_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async reset rgb_o", 32'(rgb_o), 32'h0);
    check("async reset hSync_o", 32'(hSync_o), 32'd1);
    check("async reset vSync_o", 32'(vSync_o), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("held reset rgb_o", 32'(rgb_o), 32'h0);
    check("held reset hSync_o", 32'(hSync_o), 32'd1);
    reset_n = 1'b1;
    clear_hist();
    frame_id = 5;
    step(36, 0, 1'b0);
    step(36, 1, 1'b0);
    for (int h = 200; h <= 262; h++) step(36, h, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_vga_renderer.md
Name: board_vga_renderer

Overview:
- Pixel-generation stage between the game machine's 256-bit board output and the VGA pins.
- Consumes the display controller's hCount/vCount/bright and the 16x16 board, and produces registered 12-bit RGB plus hSync/vSync delayed to match.
- Draws the board as a centred 480x480 square of 30x30-pixel cells.
- Snapshots the board once per frame, during vertical blanking, to prevent tearing, and emits a frame pulse that the game machine can use to step generations between frames.

Parameters:
- H_BOARD_X0, 224, hCount of the board's left edge (144 + 80).
- V_ACTIVE_START, 35, vCount of the first visible line.
- CELL_PX, 30, cell edge length in pixels.
- N, 16, cells per row and per column.
- ALIVE_RGB, 12'h0F0, colour of a live cell.
- DEAD_RGB, 12'h111, colour of a dead cell.
- BG_RGB, 12'h000, colour outside the board.
- GRID_RGB, 12'h444, grid line colour (used only with the optional feature).

Ports:
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- board_i  in  256  live map; bit row*16+col, row 0 = top, col 0 = left.
- hCount  in  10  horizontal counter from the display controller.
- vCount  in  10  vertical counter from the display controller.
- bright  in  1  visible-area flag.
- hSync_i  in  1  horizontal sync from the display controller.
- vSync_i  in  1  vertical sync from the display controller.
- rgb_o  out  12  pixel colour {R,G,B}.
- hSync_o  out  1  hSync_i delayed 2 clk.
- vSync_o  out  1  vSync_i delayed 2 clk.
- frame_pulse_o  out  1  1-clk pulse when a snapshot is taken.

Behaviour:
- Reset (asynchronous, active-low) sets:
  - rgb_o = 0, hSync_o = 1, vSync_o = 1, frame_pulse_o = 0.
  - snapshot = 0, hc_q = 0, all cell counters 0.
  - in_x = 0, in_y = 0.
- Pixel tick: tick = (hCount != hc_q); hc_q <= hCount every clk. This handles the controller's divided pixel rate without a shared enable.
- X tracking, on tick:
  - If hCount == H_BOARD_X0: xpix = 0, col = 0, in_x = 1.
  - Else if in_x: xpix increments; on wrap from CELL_PX-1 to 0, col increments.
  - When col would reach N: in_x = 0.
- Y tracking, on tick with hCount == 0:
  - If vCount == V_ACTIVE_START: ypix = 0, row = 0, in_y = 1.
  - Else if in_y: ypix increments; on wrap, row increments.
  - When row would reach N: in_y = 0.
- After a mid-frame reset: in_y stays 0 until the next V_ACTIVE_START line, so only BG_RGB is shown until then. There is no partial-frame garbage.
- Snapshot:
  - Condition: tick, hCount == 0, vCount == V_ACTIVE_START + N*CELL_PX (515).
  - Action: snapshot <= board_i; frame_pulse_o = 1 for exactly that clk.
  - board_i changes at any other time never affect the displayed frame.
- Pipeline, 2 clk fixed latency from the input sample:
  - S1 registers: idx = row*N + col (8 bits, shift/concat, no multiplier), in_board = in_x & in_y, bright, syncs.
  - S2 registers rgb_o:
    - bright = 0 → 0.
    - else if !in_board → BG_RGB.
    - else if snapshot[idx] = 1 → ALIVE_RGB, otherwise DEAD_RGB.
- hSync_o and vSync_o pass through the same two register stages. Colour and sync therefore stay aligned.
- Boundaries:
  - Column 15 ends at hCount 703; hCount 704 → BG_RGB.
  - Row 15 ends at vCount 514.
  - The snapshot line (515) is always blanked.

Optional Feature:
- Macro: BOARD_GRID_LINES_EN.
- Defined: in-board pixels with xpix == 0 or ypix == 0 render GRID_RGB, overriding cell colour. Latency is unchanged.
- Undefined: cells fill fully and GRID_RGB is unused.

Test Plan:
- Reset: hold reset_n = 0 mid-line → rgb_o = 0, hSync_o = 1, vSync_o = 1. Release mid-frame → BG_RGB on visible pixels until vCount 35, then the board is drawn.
- Single cell: board_i bit 0 = 1, others 0, run one frame past line 515, then the next frame:
  - hCount 224..253, vCount 35..64 → 12'h0F0.
  - hCount 254 → 12'h111.
  - hCount 223 → 12'h000.
- Corner cell: bit 255 set → 12'h0F0 only at hCount 674..703, vCount 485..514. hCount 704 → 12'h000.
- Tear-free: toggle board_i every 50 clk during the visible area → displayed frame equals the value sampled at line 515 only. frame_pulse_o is high exactly 1 clk per frame, at vCount 515, hCount 0.
- Latency: drive a single-clk hSync_i low edge → hSync_o falls exactly 2 clk later. rgb change at the board edge is likewise delayed 2 clk from the hCount change.
- Grid (BOARD_GRID_LINES_EN defined): all-ones board → hCount 224 and 254 → 12'h444, hCount 225 → 12'h0F0, vCount 65 at any in-board hCount → 12'h444.
